// File: rtl/param_page_loader.sv
// Parameter page loader: on start, fetches length_page[7:0] words of page
// length_page[15:8] from parameter memory (Avalon-MM read master, one read
// outstanding) and streams them with their index over a valid/ready port.
// Latency: start->mem_read 1 cycle, start->first param_valid 3 cycles with a
// zero-wait memory, then 3 cycles per word; done pulses one cycle after the
// last accept. Backpressure: mem_waitrequest holds address/read,
// param_ready low holds data/index; both simply stretch the transfer.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   length_page, start  request: [15:8] page, [7:0] word count; 1-cycle strobe
//   mem_*               Avalon-MM read master (address, read, waitrequest,
//                       readdata, readdatavalid)
//   param_*             output beat: data, index, valid / ready
//   busy, done, error   status: not idle, completion pulse, sticky range error
module param_page_loader #(
  parameter int PAGE_WORDS = 32,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       length_page,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [DATA_W-1:0] param_data,
  output logic [7:0]        param_index,
  output logic              param_valid,
  input  logic              param_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, FIN} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] page;
  logic [7:0] length;
  logic [7:0] index;
  logic [7:0] index_inc;
  logic       req_zero;
  logic       req_over;

  // Request classification uses the live input word; it only matters in the
  // IDLE cycle where start latches that same word.
  assign req_zero  = (length_page[7:0] == 8'd0);
  assign req_over  = ({1'b0, length_page[7:0]} > 9'(PAGE_WORDS));
  assign index_inc = index + 8'd1;

  // Computed at ADDR_W bits so a high page number wraps silently.
  assign mem_address = ADDR_W'(page) * ADDR_W'(PAGE_WORDS) + ADDR_W'(index);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (req_zero || req_over) state_nxt = FIN;
          else                      state_nxt = REQ;
        end
      end
      REQ:  if (!mem_waitrequest)  state_nxt = WAIT;
      WAIT: if (mem_readdatavalid) state_nxt = OUT;
      OUT: begin
        if (param_ready) begin
          if (index_inc == length) state_nxt = FIN;
          else                     state_nxt = REQ;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    mem_read    = 1'b0;
    param_valid = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE:    busy        = 1'b0;
      REQ:     mem_read    = 1'b1;
      OUT:     param_valid = 1'b1;
      FIN:     done        = 1'b1;
      default: ;
    endcase
  end

  // Request latch, index counter, beat registers and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      page        <= 8'd0;
      length      <= 8'd0;
      index       <= 8'd0;
      error       <= 1'b0;
      param_data  <= '0;
      param_index <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            page   <= length_page[15:8];
            length <= length_page[7:0];
            index  <= 8'd0;
            error  <= req_over;
          end
        end
        WAIT: begin
          if (mem_readdatavalid) begin
            param_data  <= mem_readdata;
            param_index <= index;
          end
        end
        OUT: if (param_ready) index <= index_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_page_loader.sv
module tb_param_page_loader;

  logic        clk;
  logic        reset_n;
  logic [15:0] length_page;
  logic        start;
  logic [11:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic [31:0] param_data;
  logic [7:0]  param_index;
  logic        param_valid;
  logic        param_ready;
  logic        busy;
  logic        done;
  logic        error;

  param_page_loader #(.PAGE_WORDS(32), .ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .length_page(length_page), .start(start),
    .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .param_data(param_data), .param_index(param_index), .param_valid(param_valid),
    .param_ready(param_ready), .busy(busy), .done(done), .error(error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Parameter memory image and observation state
  logic [31:0] mem [0:4095];
  logic [11:0] obs_addr[$];
  int          obs_idx[$];
  logic [31:0] obs_dat[$];
  int cyc = 0, start_cyc = 0;
  int rd_cnt = 0, beat_cnt = 0, done_cnt = 0, done_cyc = -1;
  int first_rd = -1, first_vld = -1, last_acc = -1;
  int wr_cycles = 0, held_beats = 0;
  // Memory responder / consumer controls
  int rdv_delay = 1, pend_cnt = 0;
  logic [11:0] pend_addr = '0;
  int stall_read = -1, stall_len = 0, stall_left = 0;
  int bp_beat = -1, bp_len = 0, bp_left = 0;
  bit stall_used = 1, bp_used = 1, rand_wait = 0, rand_ready = 0;
  bit prev_stalled = 0, prev_held = 0;
  logic [11:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  logic [7:0]  prev_idx = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory slave, consumer and monitor; all drive and sample mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      mem_readdatavalid = 1'b0;
      mem_readdata      = $urandom;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = mem[pend_addr];
        end
      end
      if (reset_n && prev_stalled) begin
        check("read_hold", mem_read, 1);
        check("addr_hold", mem_address, prev_addr);
      end
      prev_stalled    = 0;
      mem_waitrequest = 1'b0;
      if (reset_n && mem_read) begin
        if (stall_left == 0 && !stall_used && rd_cnt == stall_read) begin
          stall_left = stall_len;
          stall_used = 1;
        end
        if (stall_left > 0) begin
          mem_waitrequest = 1'b1;
          stall_left--;
        end else if (rand_wait) begin
          mem_waitrequest = ($urandom_range(0, 2) == 0);
        end
        if (mem_waitrequest) begin
          prev_stalled = 1;
          prev_addr    = mem_address;
          wr_cycles++;
        end else begin
          check("one_outstanding", pend_cnt, 0);
          obs_addr.push_back(mem_address);
          rd_cnt++;
          pend_cnt  = rdv_delay;
          pend_addr = mem_address;
          if (first_rd < 0) first_rd = cyc;
        end
      end
      param_ready = 1'b1;
      if (bp_left == 0 && !bp_used && param_valid && beat_cnt == bp_beat) begin
        bp_left = bp_len;
        bp_used = 1;
      end
      if (bp_left > 0) begin
        param_ready = 1'b0;
        bp_left--;
      end else if (rand_ready) begin
        param_ready = ($urandom_range(0, 1) == 1);
      end
      if (reset_n && prev_held) begin
        check("vld_hold", param_valid, 1);
        check("data_hold", param_data, prev_data);
        check("idx_hold", param_index, prev_idx);
      end
      prev_held = 0;
      if (reset_n && param_valid) begin
        if (first_vld < 0) first_vld = cyc;
        if (param_ready) begin
          obs_idx.push_back(int'(param_index));
          obs_dat.push_back(param_data);
          beat_cnt++;
          last_acc = cyc;
        end else begin
          prev_held = 1;
          prev_data = param_data;
          prev_idx  = param_index;
          held_beats++;
        end
      end
      if (reset_n && done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_xfer(input logic [15:0] lp);
    @(negedge clk);
    obs_addr.delete(); obs_idx.delete(); obs_dat.delete();
    rd_cnt = 0; beat_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_rd = -1; first_vld = -1; last_acc = -1;
    wr_cycles = 0; held_beats = 0;
    length_page = lp;
    start       = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    start       = 1'b0;
    length_page = 16'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done_cnt == 0 && n < 3000);
    check($sformatf("%s_done_seen", tag), done_cnt > 0, 1);
    check($sformatf("%s_busy_idle", tag), busy, 0);
    @(posedge clk);
    #1;
  endtask

  // Reference: reads at (page*32+i) mod 4096, beats (i, mem[addr]), error iff length > 32.
  task automatic verify(input logic [15:0] lp, input string tag);
    int pg, len, n;
    logic [11:0] a;
    pg  = int'(lp[15:8]);
    len = int'(lp[7:0]);
    n   = (len == 0 || len > 32) ? 0 : len;
    check($sformatf("%s_reads", tag), obs_addr.size(), n);
    check($sformatf("%s_beats", tag), obs_idx.size(), n);
    for (int i = 0; i < n; i++) begin
      a = 12'((pg * 32 + i) % 4096);
      if (i < obs_addr.size()) check($sformatf("%s_addr%0d", tag, i), obs_addr[i], a);
      if (i < obs_idx.size()) begin
        check($sformatf("%s_idx%0d", tag, i), obs_idx[i], i);
        check($sformatf("%s_dat%0d", tag, i), obs_dat[i], mem[a]);
      end
    end
    check($sformatf("%s_error", tag), error, len > 32);
    check($sformatf("%s_done_once", tag), done_cnt, 1);
  endtask

  initial begin
    int n;
    logic [15:0] lp;
    reset_n = 1'b0; start = 1'b0; length_page = 16'h0000;
    mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0; param_ready = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[64] = 32'hA0; mem[65] = 32'hA1; mem[66] = 32'hA2;
    #3;
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_param_valid", param_valid, 0);
    check("rst_param_data", param_data, 0);
    check("rst_param_index", param_index, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Normal page, zero-wait memory, consumer always ready
    start_xfer(16'h0203);
    wait_done("normal");
    verify(16'h0203, "normal");
    check("normal_beat0_const", obs_dat.size() > 0 ? obs_dat[0] : 32'hX, 32'hA0);
    check("lat_first_read", first_rd - start_cyc, 1);
    check("lat_first_valid", first_vld - start_cyc, 3);
    check("lat_last_accept", last_acc - start_cyc, 9);
    check("lat_done", done_cyc - last_acc, 1);

    // Zero length
    start_xfer(16'h0500);
    wait_done("zero");
    verify(16'h0500, "zero");
    check("zero_done_lat", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);
    check("zero_no_valid", first_vld, -1);

    // Range error, then cleared by the next accepted start
    start_xfer(16'h0121);
    wait_done("range");
    verify(16'h0121, "range");
    start_xfer(16'h0101);
    check("error_cleared", error, 0);
    wait_done("after_err");
    verify(16'h0101, "after_err");

    // Memory stall on 2nd read, backpressure on 1st beat
    stall_read = 1; stall_len = 3; stall_used = 0;
    bp_beat = 0; bp_len = 4; bp_used = 0;
    start_xfer(16'h0303);
    wait_done("stall");
    verify(16'h0303, "stall");
    check("stall_wait_cycles", wr_cycles, 3);
    check("stall_held_beats", held_beats, 4);

    // Ignored second start, then reset abort during WAIT of word 1
    rdv_delay = 3;
    start_xfer(16'h0103);
    @(negedge clk);
    length_page = 16'h0207;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rd_cnt < 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_reached_read1", rd_cnt, 2);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_mem_read", mem_read, 0);
    check("abort_mem_address", mem_address, 0);
    check("abort_param_valid", param_valid, 0);
    check("abort_param_data", param_data, 0);
    check("abort_param_index", param_index, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_beats", beat_cnt, 1);
    check("abort_addr0", obs_addr.size() > 0 ? obs_addr[0] : 12'hXXX, 12'd32);
    check("abort_addr1", obs_addr.size() > 1 ? obs_addr[1] : 12'hXXX, 12'd33);
    check("late_rdv_ignored", param_valid, 0);
    rdv_delay = 1;
    start_xfer(16'h0101);
    wait_done("fresh");
    verify(16'h0101, "fresh");

    // Randomized requests with random waitrequest and param_ready
    rand_wait = 1; rand_ready = 1;
    for (int t = 0; t < 8; t++) begin
      int r;
      r = $urandom_range(0, 9);
      lp[15:8] = 8'($urandom_range(0, 255));
      if (r == 0)      lp[7:0] = 8'd0;
      else if (r == 1) lp[7:0] = 8'($urandom_range(33, 255));
      else             lp[7:0] = 8'($urandom_range(1, 32));
      start_xfer(lp);
      wait_done($sformatf("rand%0d", t));
      verify(lp, $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
